// File: rtl/cordic_phase_detector.sv
// cordic_phase_detector: pipelined CORDIC vectoring unit mapping (I,Q) to phase and
// uncompensated magnitude; one sample per clock, latency ITERATIONS+2.
module cordic_phase_detector #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 12,
    parameter int ITERATIONS  = 12,
    parameter int GUARD_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   i_i,
    input  logic [DATA_WIDTH-1:0]   q_i,
    output logic                    valid_o,
    output logic [PHASE_WIDTH-1:0]  phase_o,
    output logic [DATA_WIDTH+1:0]   mag_o
);
    localparam int XW = DATA_WIDTH + 2;
    localparam int ZW = PHASE_WIDTH + GUARD_BITS;
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    // atan(2^-k) in circle units of 2^-ZW, via its power series in Q60 fixed point
    function automatic logic [ZW-1:0] atan_lsb(input int k);
        logic [127:0] acc, term;
        int sh;
        acc = '0;
        for (int n = 0; n < 32; n++) begin
            sh = 60 - k * (2 * n + 1);
            if (sh >= 0) begin
                term = (128'd1 << sh) / 128'(2 * n + 1);
                acc  = n[0] ? acc - term : acc + term;
            end
        end
        term = ((acc << ZW) + PI_Q60) / (PI_Q60 << 1);
        return (k == 0) ? ZW'(1) << (ZW - 3) : term[ZW-1:0];
    endfunction

    logic signed [XW-1:0] x_d [ITERATIONS+1];
    logic signed [XW-1:0] y_d [ITERATIONS+1];
    logic        [ZW-1:0] z_d [ITERATIONS+1];
    logic signed [XW-1:0] x_q [ITERATIONS+1];
    logic signed [XW-1:0] y_q [ITERATIONS+1];
    logic        [ZW-1:0] z_q [ITERATIONS+1];
    logic [ITERATIONS:0]  v_q, zf_q;
    logic signed [XW-1:0] i_ext, q_ext;
    logic                 zero_d;
    logic [PHASE_WIDTH-1:0] phase_d;
    logic [XW-1:0]        mag_d;

    assign i_ext  = {{2{i_i[DATA_WIDTH-1]}}, i_i};
    assign q_ext  = {{2{q_i[DATA_WIDTH-1]}}, q_i};
    assign zero_d = (i_i == '0) && (q_i == '0);
    // left half-plane samples are rotated by pi so the micro-rotations always converge
    assign x_d[0] = i_i[DATA_WIDTH-1] ? -i_ext : i_ext;
    assign y_d[0] = i_i[DATA_WIDTH-1] ? -q_ext : q_ext;
    assign z_d[0] = i_i[DATA_WIDTH-1] ? {1'b1, {(ZW-1){1'b0}}} : '0;

    for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
        localparam logic [ZW-1:0] ATAN = atan_lsb(k);
        logic pos;
        assign pos        = ~y_q[k][XW-1];
        assign x_d[k+1]   = pos ? x_q[k] + (y_q[k] >>> k) : x_q[k] - (y_q[k] >>> k);
        assign y_d[k+1]   = pos ? y_q[k] - (x_q[k] >>> k) : y_q[k] + (x_q[k] >>> k);
        assign z_d[k+1]   = pos ? z_q[k] + ATAN : z_q[k] - ATAN;
    end

    always_comb begin
        phase_d = zf_q[ITERATIONS] ? '0
                : PHASE_WIDTH'((z_q[ITERATIONS] + (ZW'(1) << (GUARD_BITS - 1))) >> GUARD_BITS);
        mag_d   = zf_q[ITERATIONS] ? '0 : x_q[ITERATIONS];
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s <= ITERATIONS; s++) begin
            x_q[s] <= x_d[s];
            y_q[s] <= y_d[s];
            z_q[s] <= z_d[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            zf_q    <= '0;
            valid_o <= 1'b0;
            phase_o <= '0;
            mag_o   <= '0;
        end else begin
            v_q     <= {v_q[ITERATIONS-1:0], valid_i};
            zf_q    <= {zf_q[ITERATIONS-1:0], zero_d};
            valid_o <= v_q[ITERATIONS];
            phase_o <= phase_d;
            mag_o   <= mag_d;
        end
    end
endmodule

// File: tb/tb_cordic_phase_detector.sv
// tb_cordic_phase_detector: table-driven and randomized checks of the CORDIC phase
// detector against an atan2/sqrt reference model with a latency-tagged scoreboard.
module tb_cordic_phase_detector;
    localparam int  DW  = 16;
    localparam int  PW  = 12;
    localparam int  LAT = 14;
    localparam real K   = 1.6467602581;
    localparam real TWO_PI = 6.283185307179586;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] i_i = '0;
    logic [DW-1:0] q_i = '0;
    logic          valid_o;
    logic [PW-1:0] phase_o;
    logic [DW+1:0] mag_o;

    cordic_phase_detector dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .i_i(i_i), .q_i(q_i),
        .valid_o(valid_o), .phase_o(phase_o), .mag_o(mag_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int ph; real mag; bit cm; bit mono; int cyc;} exp_t;
    typedef struct {int i; int q; int ph; bit cm;} vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   checks = 0;
    int   failures = 0;
    int   last_ph = 0;

    function automatic int mdiff(input int a, input int b);
        int d;
        d = (((a - b) % 4096) + 4096) % 4096;
        return (d >= 2048) ? d - 4096 : d;
    endfunction

    function automatic int model_ph(input int i, input int q);
        return int'($atan2(real'(q), real'(i)) * 4096.0 / TWO_PI);
    endfunction

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit v, input int i, input int q, input int ph, input bit cm, input bit mono);
        @(posedge clk);
        #1;
        valid_i = v;
        i_i = DW'(i);
        q_i = DW'(q);
        if (v) sb.push_back('{ph, K * $sqrt(real'(i) * real'(i) + real'(q) * real'(q)), cm, mono, cyc + LAT});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic rand_iq(output int i, output int q);
        do begin
            i = int'($urandom_range(65535)) - 32768;
            q = int'($urandom_range(65535)) - 32768;
        end while (real'(i) * real'(i) + real'(q) * real'(q) < 1.44e8);
    endtask

    task automatic send_rand();
        int i, q;
        rand_iq(i, q);
        drive(1'b1, i, q, model_ph(i, q), 1'b1, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk(1'b0, "drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int ph;
        real d;
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_valid_o", 1, 0);
            else begin
                e  = sb.pop_front();
                ph = int'($signed(phase_o));
                d  = real'(mag_o) - e.mag;
                chk(cyc == e.cyc, "latency", cyc, e.cyc);
                chk(mdiff(ph, e.ph) inside {[-2:2]}, "phase", ph, e.ph);
                if (e.cm) chk(d <= 0.001 * e.mag && d >= -0.001 * e.mag, "mag", int'(mag_o), int'(e.mag));
                if (e.mono) chk(mdiff(ph, last_ph) inside {[0:4]}, "monotonic", ph, last_ph);
                last_ph = ph;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int i, q;
        int gap[7] = '{1, 0, 0, 1, 1, 0, 1};
        tbl = '{'{16384, 0, 0, 1'b1}, '{0, 16384, 1024, 1'b1}, '{0, -16384, -1024, 1'b1},
                '{-16384, 0, -2048, 1'b1}, '{-16384, -16384, -1536, 1'b1}, '{16384, -16384, -512, 1'b1},
                '{-32768, -32768, -1536, 1'b1}, '{32767, -32768, -512, 1'b1}, '{0, 0, 0, 1'b1},
                '{1000, 0, 0, 1'b0}, '{0, 1000, 1024, 1'b0}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(valid_o === 1'b0, "reset_valid_o", int'(valid_o), 0);
        chk(phase_o === '0, "reset_phase_o", int'(phase_o), 0);
        chk(mag_o === '0, "reset_mag_o", int'(mag_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 11; n++) begin
            drive(1'b1, tbl[n].i, tbl[n].q, tbl[n].ph, tbl[n].cm, 1'b0);
            idle(2);
        end
        drain();
        drive(1'b1, 1000, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 0, 0, 0, 1'b1, 1'b0);
        drive(1'b1, 0, 1000, 1024, 1'b0, 1'b0);
        idle(1);
        drain();
        for (int n = 0; n < 4096; n++) begin
            real th;
            th = TWO_PI * real'(n) / 4096.0;
            drive(1'b1, int'(20000.0 * $cos(th)), int'(20000.0 * $sin(th)), n, 1'b1, n != 0);
        end
        idle(1);
        drain();
        foreach (gap[n]) begin
            if (gap[n] != 0) send_rand();
            else idle(1);
        end
        idle(1);
        drain();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) != 0) send_rand();
            else idle(1);
        end
        idle(1);
        drain();
        repeat (10) send_rand();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid_i = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk(valid_o === 1'b0, "midreset_valid_o", int'(valid_o), 0);
        chk(phase_o === '0, "midreset_phase_o", int'(phase_o), 0);
        chk(mag_o === '0, "midreset_mag_o", int'(mag_o), 0);
        rst_n = 1'b1;
        rand_iq(i, q);
        drive(1'b1, i, q, model_ph(i, q), 1'b1, 1'b0);
        idle(30);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
